// File: rtl/seg_pkg.sv
// Shared constants for the seg_scan display driver: segment bit positions,
// the hex-to-segment code table and a counter width helper.
package seg_pkg;

  // Segment bit positions in the {g,f,e,d,c,b,a,dp} byte
  localparam int unsigned SEG_G  = 7;
  localparam int unsigned SEG_F  = 6;
  localparam int unsigned SEG_E  = 5;
  localparam int unsigned SEG_D  = 4;
  localparam int unsigned SEG_C  = 3;
  localparam int unsigned SEG_B  = 2;
  localparam int unsigned SEG_A  = 1;
  localparam int unsigned SEG_DP = 0;

  // Hex digit to segment byte; the dp bit is always 0 here
  localparam logic [7:0] SEG_CODES [16] = '{
    8'h7E, 8'h0C, 8'hB6, 8'h9E, 8'hCC, 8'hDA, 8'hFA, 8'h0E,
    8'hFE, 8'hDE, 8'hEE, 8'hF8, 8'h72, 8'hBC, 8'hF2, 8'hE2
  };

  // Width of a counter that must hold 0..n-1 (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_dec.sv
// Combinational hex to 7-segment decoder, output order {g,f,e,d,c,b,a}.
module seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  logic [7:0] code;

  // Table lookup, dropping the dp position
  always_comb begin
    code = SEG_CODES[hex];
    seg  = code[SEG_G:SEG_A];
  end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed N-digit common-anode 7-segment driver.
// Load strobe captures into a shadow; commit to the active set happens at
// frame boundaries (or immediately while disabled). Optional leading-zero
// blanking is built when SEG_SCAN_LZB_EN is defined.
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned BLANK_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] d_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    pending,
  output logic                    frame_tick,
  output logic                    a,
  output logic                    b,
  output logic                    c,
  output logic                    d,
  output logic                    e,
  output logic                    f,
  output logic                    g,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   ds
);

  localparam int unsigned DIV_W = cnt_width(SCAN_DIV);
  localparam int unsigned IDX_W = cnt_width(NUM_DIGITS);

  logic [DIV_W-1:0]        div_q;
  logic [IDX_W-1:0]        idx_q;
  logic [4*NUM_DIGITS-1:0] shadow_d;
  logic [4*NUM_DIGITS-1:0] active_d;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   active_dp;
  logic                    pending_q;
  logic                    frame_tick_q;
  logic [7:0]              seg_q;
  logic [NUM_DIGITS-1:0]   ds_q;

  logic                    slot_end;
  logic                    frame_end;
  logic                    commit;
  logic                    blank_slot;
  logic [3:0]              cur_digit;
  logic                    cur_dp;
  logic [6:0]              cur_seg;
  logic [NUM_DIGITS-1:0]   lzb_mask;
  logic [7:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   ds_nxt;

  assign slot_end  = enable && (div_q == DIV_W'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
  // While disabled there is no frame to wait for, so commit at once
  assign commit    = pending_q && (frame_end || !enable);

  // Slot divider and digit index; held at zero while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (!enable) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (slot_end) begin
      div_q <= '0;
      idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Shadow capture and commit; a load coinciding with commit keeps pending set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_d  <= '0;
      shadow_dp <= '0;
      active_d  <= '0;
      active_dp <= '0;
      pending_q <= 1'b0;
    end else begin
      if (load) begin
        shadow_d  <= d_in;
        shadow_dp <= dp_in;
      end
      if (commit) begin
        active_d  <= shadow_d;
        active_dp <= shadow_dp;
      end
      pending_q <= load | (pending_q & ~commit);
    end
  end

  assign cur_digit = active_d[{idx_q, 2'b00} +: 4];
  assign cur_dp    = active_dp[idx_q];

  seg_dec u_dec (
    .hex (cur_digit),
    .seg (cur_seg)
  );

`ifdef SEG_SCAN_LZB_EN
  // Blank zero digits from the MSD down until a nonzero digit or a set dp
  always_comb begin
    logic leading;
    lzb_mask = '0;
    leading  = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
      if (leading && (active_d[4*(NUM_DIGITS-1-k) +: 4] == 4'h0)
          && !active_dp[NUM_DIGITS-1-k]) begin
        lzb_mask[NUM_DIGITS-1-k] = 1'b1;
      end else begin
        leading = 1'b0;
      end
    end
  end
`else
  assign lzb_mask = '0;
`endif

  assign blank_slot = !enable || (32'(div_q) < BLANK_CYC) || lzb_mask[idx_q];

  // Next pin values for the current slot position
  always_comb begin
    ds_nxt  = '1;
    seg_nxt = '0;
    if (!blank_slot) begin
      ds_nxt[idx_q] = 1'b0;
      seg_nxt       = {cur_seg, cur_dp};
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ds_q         <= '1;
      seg_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      ds_q         <= ds_nxt;
      seg_q        <= seg_nxt;
      frame_tick_q <= frame_end;
    end
  end

  assign ds         = ds_q;
  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;
  assign g          = seg_q[SEG_G];
  assign f          = seg_q[SEG_F];
  assign e          = seg_q[SEG_E];
  assign d          = seg_q[SEG_D];
  assign c          = seg_q[SEG_C];
  assign b          = seg_q[SEG_B];
  assign a          = seg_q[SEG_A];
  assign dp         = seg_q[SEG_DP];

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan (4 digits, 4-cycle slots, 1 blank cycle).
module tb_seg_scan;

  localparam int unsigned N  = 4;
  localparam int unsigned SD = 4;
  localparam int unsigned BC = 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           enable;
  logic           load;
  logic [4*N-1:0] d_in;
  logic [N-1:0]   dp_in;
  logic           pending, frame_tick;
  logic           a, b, c, d, e, f, g, dp;
  logic [N-1:0]   ds;

  always #5 clk = ~clk;

  seg_scan #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
    .d_in(d_in), .dp_in(dp_in), .pending(pending), .frame_tick(frame_tick),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp), .ds(ds)
  );

  logic [7:0] code_tab [16] = '{
    8'h7E, 8'h0C, 8'hB6, 8'h9E, 8'hCC, 8'hDA, 8'hFA, 8'h0E,
    8'hFE, 8'hDE, 8'hEE, 8'hF8, 8'h72, 8'hBC, 8'hF2, 8'hE2
  };

  // Reference model state: scan position as a plain count of enabled cycles
  int unsigned en_cnt;
  logic [3:0]  m_sd [N];
  logic [3:0]  m_ad [N];
  logic        m_sdp [N];
  logic        m_adp [N];
  logic        m_pend;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4*N-1:0] d;
    logic [N-1:0]   dpv;
    int unsigned    dig;
    logic [N-1:0]   exp_ds;
    logic [7:0]     exp_seg;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [7:0] seg_bus();
    return {g, f, e, d, c, b, a, dp};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    en_cnt = 0;
    m_pend = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_sd[i] = '0; m_ad[i] = '0; m_sdp[i] = 1'b0; m_adp[i] = 1'b0;
    end
  endtask

  function automatic logic [N-1:0] lead_blank();
    logic [N-1:0] m;
    m = '0;
`ifdef SEG_SCAN_LZB_EN
    for (int i = N - 1; i >= 1; i--) begin
      if (m_ad[i] == 4'h0 && !m_adp[i]) m[i] = 1'b1;
      else break;
    end
`endif
    return m;
  endfunction

  function automatic bit at_boundary();
    return enable && (en_cnt % SD == SD - 1) && ((en_cnt / SD) % N == N - 1);
  endfunction

  // One clock: predict from pre-edge model state, advance model, compare
  task automatic tick();
    int unsigned  dv, ix;
    logic [N-1:0] eds, lz;
    logic [7:0]   eseg;
    logic         fb, cm;
    dv   = en_cnt % SD;
    ix   = (en_cnt / SD) % N;
    lz   = lead_blank();
    eds  = '1;
    eseg = '0;
    if (enable && dv >= BC && !lz[ix]) begin
      eds[ix] = 1'b0;
      eseg    = {code_tab[m_ad[ix]][7:1], m_adp[ix]};
    end
    fb = at_boundary();
    cm = m_pend && (fb || !enable);
    if (cm) for (int i = 0; i < N; i++) begin m_ad[i] = m_sd[i]; m_adp[i] = m_sdp[i]; end
    if (load) begin
      m_pend = 1'b1;
      for (int i = 0; i < N; i++) begin m_sd[i] = d_in[4*i +: 4]; m_sdp[i] = dp_in[i]; end
    end else if (cm) begin
      m_pend = 1'b0;
    end
    en_cnt = enable ? en_cnt + 1 : 0;
    @(posedge clk); #1;
    chk("ds", 32'(ds), 32'(eds));
    chk("seg", 32'(seg_bus()), 32'(eseg));
    chk("frame_tick", 32'(frame_tick), 32'(fb));
    chk("pending", 32'(pending), 32'(m_pend));
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [4*N-1:0] dv, input logic [N-1:0] pv);
    load = 1'b1; d_in = dv; dp_in = pv;
    tick();
    load = 1'b0;
  endtask

  task automatic goto_boundary();
    int unsigned k;
    k = 0;
    while (!at_boundary() && k < 2 * N * SD) begin tick(); k++; end
    chk("boundary_reached", 32'(at_boundary()), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{16'h12AF, 4'b0010, 0, 4'b1110, 8'hE2};
    vecs[1]  = '{16'h12AF, 4'b0010, 1, 4'b1101, 8'hEF};
    vecs[2]  = '{16'h12AF, 4'b0010, 2, 4'b1011, 8'hB6};
    vecs[3]  = '{16'h12AF, 4'b0010, 3, 4'b0111, 8'h0C};
    vecs[4]  = '{16'h9876, 4'b1000, 0, 4'b1110, 8'hFA};
    vecs[5]  = '{16'h9876, 4'b1000, 3, 4'b0111, 8'hDF};
    vecs[6]  = '{16'hC3B4, 4'b0000, 0, 4'b1110, 8'hCC};
    vecs[7]  = '{16'hC3B4, 4'b0000, 1, 4'b1101, 8'hF8};
    vecs[8]  = '{16'hC3B4, 4'b0000, 2, 4'b1011, 8'h9E};
    vecs[9]  = '{16'hC3B4, 4'b0000, 3, 4'b0111, 8'h72};
    vecs[10] = '{16'hDE05, 4'b0001, 0, 4'b1110, 8'hDB};
    vecs[11] = '{16'hDE05, 4'b0001, 1, 4'b1101, 8'h7E};
    vecs[12] = '{16'hDE05, 4'b0001, 2, 4'b1011, 8'hF2};
    vecs[13] = '{16'hDE05, 4'b0001, 3, 4'b0111, 8'hBC};

    rst_n = 1'b0; enable = 1'b0; load = 1'b0; d_in = '0; dp_in = '0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_ds", 32'(ds), 32'hF);
    chk("rst_seg", 32'(seg_bus()), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_frame_tick", 32'(frame_tick), 32'h0);
    rst_n = 1'b1; enable = 1'b1;

    // Free scan of the reset (all zero) data
    run(2 * N * SD);

    // Mid-frame load, shown only after the next frame tick
    run(5);
    do_load(16'h12AF, 4'b0010);
    chk("pend_after_load", 32'(pending), 32'd1);
    begin
      int unsigned k;
      k = 0;
      while (!frame_tick && k < 2 * N * SD) begin tick(); k++; end
      chk("frame_tick_seen", 32'(frame_tick), 32'd1);
      chk("pend_after_commit", 32'(pending), 32'd0);
    end
    run(N * SD);

    // Last load wins, then a load on the exact boundary cycle
    run(2);
    do_load(16'h1111, 4'b0000);
    do_load(16'h2222, 4'b0000);
    run(2 * N * SD);
    goto_boundary();
    do_load(16'h3333, 4'b0101);
    chk("pend_boundary_load", 32'(pending), 32'd1);
    run(2 * N * SD);

    // Disable mid-slot, load while dark, re-enable at digit 0
    run(SD + 1);
    enable = 1'b0;
    tick();
    chk("dis_ds", 32'(ds), 32'hF);
    chk("dis_seg", 32'(seg_bus()), 32'h0);
    do_load(16'h0009, 4'b0000);
    tick();
    chk("dis_committed", 32'(pending), 32'd0);
    enable = 1'b1;
    run(N * SD);

    // Asynchronous reset mid-slot with data pending
    run(3);
    do_load(16'hABCD, 4'b1111);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ds", 32'(ds), 32'hF);
    chk("arst_seg", 32'(seg_bus()), 32'h0);
    chk("arst_pending", 32'(pending), 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(N * SD + 2);

    // Decode table: load while disabled, then step to the wanted digit
    for (int i = 0; i < 14; i++) begin
      enable = 1'b0;
      do_load(vecs[i].d, vecs[i].dpv);
      tick();
      enable = 1'b1;
      run(vecs[i].dig * SD + 2);
      chk("vec_ds", 32'(ds), 32'(vecs[i].exp_ds));
      chk("vec_seg", 32'(seg_bus()), 32'(vecs[i].exp_seg));
    end

    // Leading-zero candidates
    enable = 1'b0;
    do_load(16'h0050, 4'b0000);
    enable = 1'b1;
    run(N * SD + 2);
    do_load(16'h0050, 4'b1000);
    run(2 * N * SD);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      enable = ($urandom_range(0, 19) != 0);
      load   = ($urandom_range(0, 9) == 0);
      d_in   = 16'($urandom);
      if ($urandom_range(0, 3) == 0) d_in[15:8] = 8'h00;
      dp_in  = 4'($urandom_range(0, 15));
      tick();
    end
    load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
